// File: rtl/sram_pkg.sv
// Shared definitions for the async-SRAM responder: bus widths, default
// access timing and the controller state encoding.
package sram_pkg;

    localparam int SRAM_AW      = 20;
    localparam int SRAM_DW      = 48;
    localparam int RD_WAIT_DEF  = 2;
    localparam int WR_PULSE_DEF = 2;
    localparam int CNT_W_DEF    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sram_phy_ctrl.sv
// Strobe/ack responder that turns one bus request into a timed async-SRAM
// read or write cycle; every output, including the pad controls, is registered.
module sram_phy_ctrl
    import sram_pkg::*;
#(
    parameter int RD_WAIT  = RD_WAIT_DEF,
    parameter int WR_PULSE = WR_PULSE_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic               clk50,
    input  logic               rst,
    input  logic               stb,
    input  logic [SRAM_AW-1:0] addra,
    input  logic [SRAM_DW-1:0] dina,
    input  logic               we,
    output logic [SRAM_DW-1:0] douta,
    output logic               ack,
    output logic               busy,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic [SRAM_DW-1:0] sram_dq_o,
    output logic               sram_dq_oe
);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [SRAM_AW-1:0] addr_reg, addr_next;
    logic [SRAM_DW-1:0] dq_o_reg, dq_o_next;
    logic [SRAM_DW-1:0] douta_reg, douta_next;
    logic               ce_n_reg, ce_n_next;
    logic               oe_n_reg, oe_n_next;
    logic               we_n_reg, we_n_next;
    logic               dq_oe_reg, dq_oe_next;
    logic               ack_reg, ack_next;
    logic               busy_reg, busy_next;

    // Asynchronous clear so the pads are released (we_n high, dq undriven)
    // the moment reset asserts, not at the next edge.
    always_ff @(posedge clk50 or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            dq_o_reg  <= '0;
            douta_reg <= '0;
            ce_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
            dq_oe_reg <= 1'b0;
            ack_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            dq_o_reg  <= dq_o_next;
            douta_reg <= douta_next;
            ce_n_reg  <= ce_n_next;
            oe_n_reg  <= oe_n_next;
            we_n_reg  <= we_n_next;
            dq_oe_reg <= dq_oe_next;
            ack_reg   <= ack_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        dq_o_next  = dq_o_reg;
        douta_next = douta_reg;
        ce_n_next  = ce_n_reg;
        oe_n_next  = oe_n_reg;
        we_n_next  = we_n_reg;
        dq_oe_next = dq_oe_reg;
        ack_next   = 1'b0;
        busy_next  = busy_reg;

        case (state_reg)
            ST_IDLE: begin
                if (stb) begin
                    addr_next = addra;
                    dq_o_next = dina;
                    busy_next = 1'b1;
                    ce_n_next = 1'b0;
                    if (we) begin
                        state_next = ST_WR_SETUP;
                        dq_oe_next = 1'b1;
                    end else begin
                        state_next = ST_RD;
                        oe_n_next  = 1'b0;
                        cnt_next   = RD_LOAD;
                    end
                end
            end
            ST_RD: begin
                if (cnt_reg == '0) begin
                    douta_next = sram_dq_i;
                    state_next = ST_DONE;
                    ack_next   = 1'b1;
                    ce_n_next  = 1'b1;
                    oe_n_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
            ST_WR_SETUP: begin
                state_next = ST_WR_PULSE;
                we_n_next  = 1'b0;
                cnt_next   = WR_LOAD;
            end
            ST_WR_PULSE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_WR_HOLD;
                    we_n_next  = 1'b1;
                    ack_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_WR_HOLD: begin
                // Data stays driven one cycle past we_n rising for hold time.
                state_next = ST_IDLE;
                ce_n_next  = 1'b1;
                dq_oe_next = 1'b0;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
                ce_n_next  = 1'b1;
                oe_n_next  = 1'b1;
                we_n_next  = 1'b1;
                dq_oe_next = 1'b0;
                busy_next  = 1'b0;
                cnt_next   = '0;
            end
        endcase
    end

    assign douta      = douta_reg;
    assign ack        = ack_reg;
    assign busy       = busy_reg;
    assign sram_addr  = addr_reg;
    assign sram_ce_n  = ce_n_reg;
    assign sram_oe_n  = oe_n_reg;
    assign sram_we_n  = we_n_reg;
    assign sram_dq_o  = dq_o_reg;
    assign sram_dq_oe = dq_oe_reg;

endmodule

// File: doc/sram_phy_ctrl.md
Name: sram_phy_ctrl

Overview:
Responder end of the internal SRAM strobe/ack bus. Accepts one read or write per strobe from the bus initiator and converts it into a timed async-SRAM pin sequence (CE/OE/WE, 20-bit address, 48-bit data). Returns read data and a one-cycle ack. Sits between the SRAM initialisation/arbitration front-end and the board SRAM pads; the top level maps the split dq_i/dq_o/dq_oe signals onto IOBUFs.

Parameters:
RD_WAIT, 2, cycles OE/address held before read data is sampled (min 1)
WR_PULSE, 2, cycles WE_n is held low (min 1)
CNT_W, 3, width of the timing counter; must hold max(RD_WAIT, WR_PULSE)

Ports:
clk50  in  1  sole clock, all logic on posedge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
stb  in  1  request strobe, held until ack
addra  in  20  word address, sampled at accept
dina  in  48  write data, sampled at accept
we  in  1  1=write, 0=read, sampled at accept
douta  out  48  read data, registered, valid from ack cycle until the next read ack
ack  out  1  one-cycle completion pulse
busy  out  1  high from the cycle after accept through the ack cycle
sram_addr  out  20  SRAM address pins
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low
sram_dq_i  in  48  data pins, input path
sram_dq_o  out  48  data pins, output path
sram_dq_oe  out  1  1=drive sram_dq_o onto the pads

Behaviour:
- All outputs are registered. Reset values: ce_n=1, oe_n=1, we_n=1, dq_oe=0, sram_addr=0, dq_o=0, douta=0, ack=0, busy=0, state=IDLE, counter=0.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: when stb=1 at edge T, latch addra, dina and we.
  - If we=1, go to WR_SETUP; otherwise go to RD. The latched values drive sram_addr and dq_o from T+1.
- Read: RD lasts RD_WAIT cycles (T+1..T+RD_WAIT) with ce_n=0, oe_n=0, we_n=1, dq_oe=0.
  - At the last RD edge, sram_dq_i is captured into douta.
  - State moves to DONE: ack=1 at T+RD_WAIT+1 (T+3 with defaults), ce_n=1, oe_n=1.
- Write:
  - WR_SETUP (T+1): ce_n=0, dq_oe=1, we_n=1, oe_n=1.
  - WR_PULSE: we_n=0 for exactly WR_PULSE cycles (T+2..T+1+WR_PULSE).
  - WR_HOLD (T+2+WR_PULSE, T+4 with defaults): we_n=1, ce_n=0, dq_oe=1, ack=1.
  - Next cycle: IDLE with dq_oe=0 and ce_n=1.
  - sram_addr and dq_o stay stable for the whole write; they never change while we_n=0.
- DONE (reads only) returns to IDLE after one cycle. A write ack occurs in WR_HOLD, so writes bypass DONE.
- Ack rules:
  - Exactly one ack per accepted request.
  - ack is never asserted in IDLE.
  - The initiator updates addra/dina/we on the ack edge or drops stb.
  - IDLE re-samples stb on the cycle after ack. With stb held high, back-to-back period is RD_WAIT+2 cycles for reads (4 with defaults) and WR_PULSE+3 cycles for writes (5 with defaults).
- stb deasserted mid-transaction: the transaction completes with full timing and ack still pulses. Writes are never truncated.
- douta holds its last read value across writes and idle periods.
- Timing counter: loads the phase length minus 1, counts down, and the phase ends at 0. No wrap beyond 0.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge (we_n high and dq_oe low at once). The in-flight access is aborted and no ack is issued. After reset release, the first accept is possible at the first edge with stb=1.
- Invariants:
  - oe_n=0 and dq_oe=1 never occur together.
  - we_n=0 only while ce_n=0 and dq_oe=1.

Decomposition:
- Shared package sram_pkg: state encoding, default RD_WAIT/WR_PULSE constants, SRAM_AW=20, SRAM_DW=48.
- No sub-module. The FSM plus counter is a single block; pad tri-stating stays at the top level.

Test Plan:
- Reset: hold rst=0 with stb=1 -> all outputs at reset values; no accept until rst=1.
- Single read: stb=1, we=0, addra=20'h12345 accepted at T, sram_dq_i=48'hA5A5_0000_1234 from T+1 -> oe_n=0 at T+1..T+2, sram_addr=20'h12345, ack only at T+3, douta=48'hA5A5_0000_1234.
- Single write: addra=20'h80001, dina=48'h0000_0808_0000 at T -> dq_oe=1 at T+1..T+4, we_n=0 exactly at T+2..T+3, ack at T+4, dq_o stable throughout, dq_oe=0 at T+5.
- Burst: stb held, 128 writes to 20'h80000..20'h8007F, with addra/dina updated on each ack -> one ack every 5 cycles, 128 acks total, sram_addr sequence matches, no we_n glitch between words.
- Abandon: stb dropped at T+2 of a write -> we_n still low for 2 full cycles, ack at T+4, controller returns to IDLE.
- Async reset: rst=0 asserted between edges during we_n=0 -> we_n=1 and dq_oe=0 before the next edge, no ack; a subsequent read after release completes normally.
